// File: rtl/handshake_rr_arb_slice.sv
// Round-robin arbiter merging NUM_REQ packet streams onto one registered
// valid/ready stage; a winner keeps the stage until its last beat is accepted.
module handshake_rr_arb_slice #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [ID_W-1:0]           out_id,
   input  logic                      out_ready,
   output logic                      dbg_state,
   output logic [ID_W-1:0]           dbg_rr_ptr,
   output logic [ID_W-1:0]           dbg_lock_id
);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // ready never depends on anything but the stage being free and the grant.
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t              state, state_next;
   logic [ID_W-1:0]     rr_ptr, lock_id, grant, rr_next;
   logic [ID_W:0]       idx;
   logic                grant_ok, slot_free, accept;
   logic                sel_valid, sel_last;
   logic [DATA_W-1:0]   sel_data;

   assign slot_free = ~out_valid | out_ready;

   // Rotating search from rr_ptr; the wrap is an explicit subtract so that
   // non-power-of-two NUM_REQ never lands on a missing requester.
   always_comb begin
      grant    = lock_id;
      grant_ok = 1'b0;
      idx      = '0;
      if (state == LOCKED) begin
         grant_ok = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
               idx = idx - (ID_W+1)'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!grant_ok && idx == (ID_W+1)'(i) && req_valid[i]) begin
                  grant    = ID_W'(i);
                  grant_ok = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[i*DATA_W +: DATA_W];
            req_ready[i] = slot_free & grant_ok;
         end
      end
   end

   assign accept  = slot_free & grant_ok & sel_valid;
   assign rr_next = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && !sel_last) state_next = LOCKED;
         LOCKED:  if (accept && sel_last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lock_id <= '0;
         rr_ptr  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && accept && !sel_last)
            lock_id <= grant;
         if (accept && sel_last)
            rr_ptr <= rr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_last  <= sel_last;
         out_id    <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign dbg_state   = state;
   assign dbg_rr_ptr  = rr_ptr;
   assign dbg_lock_id = lock_id;

endmodule

// File: tb/tb_handshake_rr_arb_slice.sv
// Bench for handshake_rr_arb_slice: vector table, directed corner sequences,
// random traffic against a packet-level model, and a 3-requester wrap instance.
module tb_handshake_rr_arb_slice;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [127:0] req_data;
   logic         out_valid, out_last, out_ready, dbg_state;
   logic [31:0]  out_data;
   logic [1:0]   out_id, dbg_rr_ptr, dbg_lock_id;

   logic [2:0]   v3, l3, r3;
   logic [95:0]  d3;
   logic         ov3, ol3, or3, st3;
   logic [31:0]  od3;
   logic [1:0]   oid3, rr3, lk3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   handshake_rr_arb_slice #(.NUM_REQ(4), .DATA_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_id(out_id),
      .out_ready(out_ready), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr),
      .dbg_lock_id(dbg_lock_id)
   );

   handshake_rr_arb_slice #(.NUM_REQ(3), .DATA_W(32)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
      .req_last(l3), .req_ready(r3), .out_valid(ov3),
      .out_data(od3), .out_last(ol3), .out_id(oid3),
      .out_ready(or3), .dbg_state(st3), .dbg_rr_ptr(rr3),
      .dbg_lock_id(lk3)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] v);
      req_data[i*32 +: 32] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
      v3 = '0; l3 = '0; d3 = '0; or3 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   // Apply one cycle of inputs, check the combinational ready, then the registered outputs.
   task automatic cyc_check(input string name, input logic [3:0] v, input logic [3:0] l,
                            input logic ordy, input logic [3:0] exp_rdy, input logic exp_ov,
                            input logic [1:0] exp_id, input logic exp_last, input logic [31:0] exp_data);
      req_valid = v; req_last = l; out_ready = ordy;
      #1;
      check({name, "_ready"}, 64'(req_ready), 64'(exp_rdy));
      tick();
      check({name, "_out"}, {28'd0, out_valid, out_last, out_id, out_data},
            {28'd0, exp_ov, exp_last, exp_id, exp_data});
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       ordy;
      logic [3:0] exp_ready;
      logic       exp_ov;
      logic [1:0] exp_id;
      logic       exp_last;
   } vec_t;

   vec_t tbl[14];

   // Packet-level reference state for random traffic.
   logic        m_ov, m_last, m_locked;
   logic [31:0] m_data;
   int          m_id, m_lock_id, m_rr;

   initial begin
      tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
      tbl[7]  = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
      tbl[8]  = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
      tbl[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b0};
      tbl[10] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tbl[11] = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[12] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};

      // Reset values
      do_reset();
      check("reset_out", {28'd0, out_valid, out_last, out_id, out_data}, 64'd0);
      check("reset_fsm", {58'd0, dbg_state, dbg_rr_ptr, dbg_lock_id}, 64'd0);

      // Vector table
      for (int i = 0; i < 4; i++) set_lane(i, 32'hC0 + 32'(i));
      for (int i = 0; i < 14; i++)
         cyc_check($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].last, tbl[i].ordy,
                   tbl[i].exp_ready, tbl[i].exp_ov, tbl[i].exp_id, tbl[i].exp_last,
                   32'hC0 + 32'(tbl[i].exp_id));

      // Single 3-beat packet from requester 1
      do_reset();
      set_lane(1, 32'hA0);
      cyc_check("pkt_b0", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hA0);
      check("pkt_locked", 64'(dbg_state), 64'd1);
      set_lane(1, 32'hA1);
      cyc_check("pkt_b1", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 32'hA1);
      set_lane(1, 32'hA2);
      cyc_check("pkt_b2", 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 32'hA2);
      check("pkt_rr", {61'd0, dbg_state, dbg_rr_ptr}, 64'd2);
      cyc_check("pkt_drain", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 32'hA2);

      // Lock with a gap while requester 2 waits
      do_reset();
      set_lane(2, 32'hE2);
      set_lane(0, 32'hB0);
      cyc_check("lock_b0", 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 32'hB0);
      cyc_check("lock_gap1", 4'b0100, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'hB0);
      cyc_check("lock_gap2", 4'b0100, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 32'hB0);
      set_lane(0, 32'hB1);
      cyc_check("lock_b1", 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 32'hB1);
      set_lane(0, 32'hB2);
      cyc_check("lock_b2", 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'hB2);
      cyc_check("lock_next", 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 32'hE2);

      // Backpressure: 0x55 held for 5 cycles, then the pending beat loads immediately
      do_reset();
      set_lane(0, 32'h55);
      cyc_check("bp_fill", 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h55);
      set_lane(0, 32'h66);
      set_lane(1, 32'h77);
      for (int i = 0; i < 5; i++)
         cyc_check($sformatf("bp_hold%0d", i), 4'b0011, 4'b0011, 1'b0, 4'b0000,
                   1'b1, 2'd0, 1'b1, 32'h55);
      cyc_check("bp_release", 4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h77);

      // Reset in the middle of a packet from requester 3
      do_reset();
      set_lane(3, 32'hD0);
      cyc_check("rst_b0", 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 32'hD0);
      check("rst_locked", {62'd0, dbg_state, 1'b0}, 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", {62'd0, out_valid, dbg_state}, 64'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_lane(i, 32'hF0 + 32'(i));
      cyc_check("rst_regrant", 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'hF0);

      // NUM_REQ=3 wrap
      do_reset();
      for (int i = 0; i < 3; i++) d3[i*32 +: 32] = 32'h30 + 32'(i);
      v3 = 3'b111; l3 = 3'b111; or3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("wrap3_out%0d", k), {30'd0, ov3, oid3, od3},
               {30'd0, 1'b1, 2'(k % 3), 32'h30 + 32'(k % 3)});
         check($sformatf("wrap3_rr%0d", k), 64'(rr3), 64'((k % 3 + 1) % 3));
      end
      v3 = '0;

      // Random traffic against the packet-level model
      do_reset();
      m_ov = 1'b0; m_last = 1'b0; m_data = '0; m_id = 0;
      m_locked = 1'b0; m_lock_id = 0; m_rr = 0;
      for (int c = 0; c < 400; c++) begin
         int          g;
         logic        has, free;
         logic [3:0]  exp_rdy;
         req_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            req_last[i] = ($urandom_range(0, 2) == 0);
            set_lane(i, $urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         free = !m_ov || out_ready;
         has = 1'b0; g = 0;
         if (m_locked) begin
            has = 1'b1; g = m_lock_id;
         end else begin
            for (int k = 0; k < 4; k++)
               if (!has && req_valid[(m_rr + k) % 4]) begin
                  has = 1'b1; g = (m_rr + k) % 4;
               end
         end
         exp_rdy = (free && has) ? 4'(1 << g) : 4'b0000;
         #1;
         check("rand_ready", 64'(req_ready), 64'(exp_rdy));
         if (free && has && req_valid[g]) begin
            m_ov = 1'b1; m_data = req_data[g*32 +: 32]; m_last = req_last[g]; m_id = g;
            if (!m_locked && !req_last[g]) begin
               m_locked = 1'b1; m_lock_id = g;
            end else if (m_locked && req_last[g]) begin
               m_locked = 1'b0;
            end
            if (req_last[g]) m_rr = (g + 1) % 4;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         tick();
         check("rand_out", {28'd0, out_valid, out_last, out_id, out_data},
               {28'd0, m_ov, m_last, 2'(m_id), m_data});
         check("rand_fsm", {61'd0, dbg_state, dbg_rr_ptr}, {61'd0, m_locked, 2'(m_rr)});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/handshake_rr_arb_slice.md
Name: handshake_rr_arb_slice

Overview:
- Round-robin arbiter that shares one forward-registered valid/ready pipeline stage among NUM_REQ upstream requesters.
- Transfers are packet-based: once a requester wins, it holds the stage until its last beat is accepted.
- Output is fully registered (valid, data, last, id) and drives one downstream consumer.
- Used wherever several producers must merge onto a single handshake channel without bubbles.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, payload width per requester.
- ID_W (local, derived), $clog2(NUM_REQ), width of requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  per-requester end-of-packet flag.
- req_ready  output  NUM_REQ  per-requester ready.
- out_valid  output  1  registered output valid.
- out_data  output  DATA_W  registered payload.
- out_last  output  1  registered end-of-packet flag.
- out_id  output  ID_W  index of the requester that supplied the current beat.
- out_ready  input  1  downstream ready.

Behaviour:
- **Reset values:** out_valid=0, out_data=0, out_last=0, out_id=0, rr_ptr=0, lock_id=0, state=IDLE. Reset is asynchronous and may occur mid-packet; any partial packet is dropped and arbitration restarts at requester 0.
- **Stage free:** slot_free = ~out_valid | out_ready. This is combinational, giving full throughput and a 1-cycle accept-to-out_valid latency.
- **Grant in IDLE:** search req_valid starting at rr_ptr, ascending with wrap-around modulo NUM_REQ. The first asserted index is the grant. If no requester is valid, there is no grant.
- **Grant in LOCKED:** grant = lock_id, independent of the other valids.
- **req_ready:**
  - req_ready[i] = slot_free & (grant==i).
  - In IDLE, grant also requires req_valid[i].
  - In LOCKED, req_ready[lock_id] = slot_free even when its valid is low; all other req_ready bits are 0.
  - No requester is ever ready when out_valid=1 and out_ready=0.
- **Accept:** accept = slot_free & req_valid[grant] & (grant valid). On accept, register out_data=req_data[grant], out_last=req_last[grant], out_id=grant, out_valid=1.
- **Drain without accept:** if out_ready=1 and there is no accept, out_valid clears to 0. Data, last and id hold their values.
- **Hold:** if out_valid=1 and out_ready=0, all out_* signals hold stable.
- **State machine:**
  - IDLE -> LOCKED on an accepted beat with req_last=0; lock_id=grant.
  - IDLE stays IDLE on an accepted beat with req_last=1 (single-beat packet).
  - LOCKED -> IDLE on an accepted beat from lock_id with req_last=1.
  - In LOCKED, gaps (req_valid[lock_id]=0) keep the lock. There is no timeout.
- **rr_ptr update:** only on acceptance of a last beat, rr_ptr = (grant+1) mod NUM_REQ. Wrap for non-power-of-two NUM_REQ must be explicit, not a bit truncation.
- **Concurrency:** drain and fill in the same cycle (out_valid=1, out_ready=1, accept) produce back-to-back beats with no bubble.
- **Ignored inputs:** req_data and req_last of non-granted requesters are ignored.

Test Plan:
- **Single packet:** only req1 sends a 3-beat packet 0xA0,0xA1,0xA2 (last on 3rd) with out_ready=1 -> out_data appears on consecutive cycles, 1 cycle after each accept. out_id=1, out_last only on 0xA2, rr_ptr=2 afterwards.
- **Fairness:** all 4 requesters continuously valid with single-beat packets, out_ready=1 -> out_id sequence 0,1,2,3,0,1 with no idle cycles.
- **Lock:** req0 sends a 3-beat packet with a 2-cycle valid gap after beat 1, while req2 is constantly valid -> req_ready[2]=0 throughout; out_id=0 for all 3 beats, then req2 is granted on the next cycle.
- **Backpressure:** fill the stage with 0x55, then hold out_ready=0 for 5 cycles -> out_valid=1 and out_data=0x55 stable, req_ready all 0. After out_ready=1, the next pending beat loads in the same cycle.
- **Non-power-of-two wrap:** NUM_REQ=3, all valid, single-beat -> out_id 0,1,2,0; rr_ptr never reaches 3.
- **Reset mid-packet:** assert rst_n=0 during a LOCKED packet from req3 -> out_valid=0 immediately. After release, state=IDLE and requesters 0..3 all valid -> first grant is out_id=0.
